// File: rtl/ppwm_pkg.sv
// Shared types for the PPWM sequencer: command opcodes and controller states.
package ppwm_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_RUN   = 2'b01,
    OP_STOP  = 2'b10,
    OP_RSVD  = 2'b11
  } ctrl_op_e;

  typedef enum logic [1:0] {
    StStop = 2'b00,
    StArm  = 2'b01,
    StRun  = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/ppwm_imem.sv
// Program memory: flop array, synchronous write and clear, asynchronous read.
module ppwm_imem #(
  parameter int unsigned INSTR_WIDTH = 7,
  parameter int unsigned PC_WIDTH    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we_i,
  input  logic [PC_WIDTH-1:0]    waddr_i,
  input  logic [INSTR_WIDTH-1:0] wdata_i,
  input  logic [PC_WIDTH-1:0]    raddr_i,
  output logic [INSTR_WIDTH-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** PC_WIDTH;

  logic [INSTR_WIDTH-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ppwm_ctrl.sv
// PPWM sequencer: command FSM, program memory, prescaled global counter and
// period-start pulse for the execution unit.
module ppwm_ctrl
  import ppwm_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH  = 8,
  parameter int unsigned INSTR_WIDTH    = 7,
  parameter int unsigned PC_WIDTH       = 4,
  parameter int unsigned PRESCALE_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [PC_WIDTH-1:0]       cmd_addr_i,
  input  logic [INSTR_WIDTH-1:0]    cmd_data_i,
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
  input  logic [PC_WIDTH-1:0]       pc_i,
  output logic [INSTR_WIDTH-1:0]    instr_o,
  output logic                      start_o,
  output logic [COUNTER_WIDTH-1:0]  global_counter_o,
  output logic                      ex_rst_o,
  output logic                      running_o,
  output logic                      err_o
);

  ctrl_state_e               state_q, state_d;
  ctrl_op_e                  op;
  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
  logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
  logic                      start_q, start_d;
  logic                      err_q, err_d;
  logic                      accept;
  logic                      tick;
  logic                      mem_we;

  assign op          = ctrl_op_e'(cmd_op_i);
  assign cmd_ready_o = (state_q != StArm);
  assign accept      = cmd_valid_i && cmd_ready_o;
  assign tick        = (presc_q == prescale_q);

  // Prescaler and counter default to cleared; only an uninterrupted StRun cycle keeps them.
  always_comb begin
    state_d    = state_q;
    presc_d    = '0;
    cnt_d      = '0;
    prescale_d = prescale_q;
    err_d      = err_q;
    start_d    = 1'b0;
    mem_we     = 1'b0;

    if (accept && op == OP_RSVD) begin
      err_d = 1'b1;
    end

    unique case (state_q)
      StStop: begin
        if (accept && op == OP_WRITE) begin
          mem_we = 1'b1;
        end else if (accept && op == OP_RUN) begin
          prescale_d = prescale_i;
          state_d    = StArm;
        end
      end
      StArm: begin
        state_d = StRun;
        start_d = 1'b1;
      end
      StRun: begin
        if (accept && op == OP_STOP) begin
          state_d = StStop;
        end else if (accept && op == OP_RUN) begin
          prescale_d = prescale_i;
          state_d    = StArm;
        end else begin
          if (accept && op == OP_WRITE) begin
            err_d = 1'b1;
          end
          if (tick) begin
            cnt_d   = cnt_q + 1'b1;
            start_d = (cnt_q == '1);
          end else begin
            presc_d = presc_q + 1'b1;
            cnt_d   = cnt_q;
          end
        end
      end
      default: state_d = StStop;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStop;
      presc_q    <= '0;
      prescale_q <= '0;
      cnt_q      <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      prescale_q <= prescale_d;
      cnt_q      <= cnt_d;
      start_q    <= start_d;
      err_q      <= err_d;
    end
  end

  ppwm_imem #(
    .INSTR_WIDTH (INSTR_WIDTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_imem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (mem_we),
    .waddr_i (cmd_addr_i),
    .wdata_i (cmd_data_i),
    .raddr_i (pc_i),
    .rdata_o (instr_o)
  );

  assign start_o          = start_q;
  assign global_counter_o = cnt_q;
  assign ex_rst_o         = (state_q != StRun);
  assign running_o        = (state_q == StRun);
  assign err_o            = err_q;

endmodule

// File: tb/tb_ppwm_ctrl.sv
// Self-checking bench for ppwm_ctrl: cycle-count based reference model plus
// directed and randomized command streams.
module tb_ppwm_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_addr = '0;
  logic [6:0] cmd_data = '0;
  logic [7:0] prescale = '0;
  logic [3:0] pc = '0;
  logic [6:0] instr;
  logic       start;
  logic [7:0] gcnt;
  logic       ex_rst;
  logic       running;
  logic       err;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  ppwm_ctrl #(
    .COUNTER_WIDTH  (8),
    .INSTR_WIDTH    (7),
    .PC_WIDTH       (4),
    .PRESCALE_WIDTH (8)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid_i      (cmd_valid),
    .cmd_ready_o      (cmd_ready),
    .cmd_op_i         (cmd_op),
    .cmd_addr_i       (cmd_addr),
    .cmd_data_i       (cmd_data),
    .prescale_i       (prescale),
    .pc_i             (pc),
    .instr_o          (instr),
    .start_o          (start),
    .global_counter_o (gcnt),
    .ex_rst_o         (ex_rst),
    .running_o        (running),
    .err_o            (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model: mode 0=stopped, 1=arming, 2=running; k counts cycles since the run began.
  int         m_mode = 0;
  int         m_k    = 0;
  int         m_p    = 0;
  logic [6:0] m_mem [16];
  bit         m_err  = 1'b0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    bit acc;
    if (rst) begin
      m_mode = 0; m_k = 0; m_p = 0; m_err = 1'b0; m_valid = 1'b1;
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
    end else begin
      acc = cmd_valid && (m_mode != 1);
      if (acc && cmd_op == 2'b11) m_err = 1'b1;
      case (m_mode)
        0: begin
          if (acc && cmd_op == 2'b00) m_mem[cmd_addr] = cmd_data;
          else if (acc && cmd_op == 2'b01) begin m_p = prescale; m_mode = 1; end
        end
        1: begin m_mode = 2; m_k = 0; end
        default: begin
          if (acc && cmd_op == 2'b10) m_mode = 0;
          else if (acc && cmd_op == 2'b01) begin m_p = prescale; m_mode = 1; end
          else begin
            if (acc && cmd_op == 2'b00) m_err = 1'b1;
            m_k++;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    bit run;
    if (m_valid) begin
      run = (m_mode == 2);
      chk("running", running, run);
      chk("ex_rst", ex_rst, !run);
      chk("cmd_ready", cmd_ready, m_mode != 1);
      chk("counter", gcnt, run ? (m_k / (m_p + 1)) % 256 : 0);
      chk("start", start, run && (m_k % ((m_p + 1) * 256) == 0));
      chk("instr", instr, m_mem[pc]);
      chk("err", err, m_err);
    end
  end

  // All stimulus changes happen 1 time unit after a rising edge.
  task automatic wait_cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd(input logic [1:0] op, input logic [3:0] a, input logic [6:0] d,
                     input logic [7:0] p);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d; prescale = p;
    wait_cyc(1);
    cmd_valid = 1'b0;
  endtask

  initial begin
    wait_cyc(2);
    rst = 1'b0;
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_ex_rst", ex_rst, 1'b1);
    chk("rst_running", running, 1'b0);
    chk("rst_start", start, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_cnt", gcnt, 8'd0);

    // Program load and readback
    cmd(2'b00, 4'd3, 7'h25, 8'd0);
    for (int a = 0; a < 16; a++) begin
      pc = 4'(a); #1;
      chk("imem_read", instr, (a == 3) ? 7'h25 : 7'h00);
    end
    wait_cyc(1);

    // prescale 0
    cmd(2'b01, 4'd0, 7'h0, 8'd0);
    chk("arm_ready", cmd_ready, 1'b0);
    chk("arm_ex_rst", ex_rst, 1'b1);
    wait_cyc(1);
    chk("run0_ex_rst", ex_rst, 1'b0);
    chk("run0_start", start, 1'b1);
    chk("run0_cnt", gcnt, 8'd0);
    wait_cyc(1);
    chk("run0_cnt1", gcnt, 8'd1);
    chk("run0_start1", start, 1'b0);
    wait_cyc(255);
    chk("run0_wrap_start", start, 1'b1);
    chk("run0_wrap_cnt", gcnt, 8'd0);

    // Restart with prescale 3
    cmd(2'b01, 4'd0, 7'h0, 8'd3);
    wait_cyc(1);
    chk("run3_start", start, 1'b1);
    wait_cyc(4);
    chk("run3_cnt1", gcnt, 8'd1);
    wait_cyc(1020);
    chk("run3_period", start, 1'b1);
    wait_cyc(800);
    chk("run3_cnt200", gcnt, 8'd200);

    // STOP mid-run
    cmd(2'b10, 4'd0, 7'h0, 8'd0);
    chk("stop_running", running, 1'b0);
    chk("stop_ex_rst", ex_rst, 1'b1);
    chk("stop_cnt", gcnt, 8'd0);
    wait_cyc(600);

    // Dropped write while running, reserved op while stopped
    cmd(2'b01, 4'd0, 7'h0, 8'd0);
    wait_cyc(3);
    cmd(2'b00, 4'd5, 7'h11, 8'd0);
    pc = 4'd5; #1;
    chk("drop_write_mem", instr, 7'h00);
    chk("drop_write_err", err, 1'b1);
    wait_cyc(1);
    cmd(2'b10, 4'd0, 7'h0, 8'd0);
    cmd(2'b11, 4'd6, 7'h22, 8'd0);
    pc = 4'd6; #1;
    chk("rsvd_mem", instr, 7'h00);
    chk("rsvd_err", err, 1'b1);
    wait_cyc(5);

    // Restart from StRun with prescale 1
    cmd(2'b01, 4'd0, 7'h0, 8'd0);
    wait_cyc(10);
    cmd(2'b01, 4'd0, 7'h0, 8'd1);
    chk("restart_ready", cmd_ready, 1'b0);
    wait_cyc(1);
    chk("restart_start", start, 1'b1);
    chk("restart_cnt0", gcnt, 8'd0);
    wait_cyc(2);
    chk("restart_cnt1", gcnt, 8'd1);
    wait_cyc(2);
    chk("restart_cnt2", gcnt, 8'd2);
    cmd(2'b10, 4'd0, 7'h0, 8'd0);

    // Randomized commands
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst       = ($urandom_range(0, 499) == 0);
      cmd_valid = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 9);
      cmd_op    = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      cmd_addr  = 4'($urandom);
      cmd_data  = 7'($urandom);
      prescale  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 2));
      pc        = 4'($urandom);
      wait_cyc(1);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    wait_cyc(2);

    // Reset erases the program and the sticky error
    cmd(2'b00, 4'd3, 7'h5a, 8'd0);
    cmd(2'b11, 4'd0, 7'h0, 8'd0);
    rst = 1'b1;
    wait_cyc(1);
    rst = 1'b0;
    pc = 4'd3; #1;
    chk("post_rst_mem", instr, 7'h00);
    chk("post_rst_err", err, 1'b0);
    wait_cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
